// File: rtl/timer_pkg.sv
// Shared register map and bit positions for the bus-mapped interval timer.
package timer_pkg;

  localparam logic [2:0] OFF_CNT_LO   = 3'd0;
  localparam logic [2:0] OFF_CNT_HI   = 3'd1;
  localparam logic [2:0] OFF_RLD_LO   = 3'd2;
  localparam logic [2:0] OFF_RLD_HI   = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;
  localparam logic [2:0] OFF_STATUS   = 3'd5;
  localparam logic [2:0] OFF_PRESCALE = 3'd6;
  localparam logic [2:0] OFF_RSVD     = 3'd7;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IRQEN = 2;
  localparam int CTRL_LOAD  = 3;

  localparam int STATUS_EXP = 0;

  // The window is 8 bytes, so only address bits above the offset are compared.
  function automatic logic win_hit(input logic [15:0] addr, input logic [15:0] base);
    return addr[15:3] == base[15:3];
  endfunction

endpackage

// File: rtl/bus_timer_if.sv
// Processor bus bundle between the core (master) and the timer (slave).
interface bus_timer_if;
  logic [15:0] address;
  logic [7:0]  wr_data;
  logic        wr_enable;
  logic [7:0]  rd_data;
  logic        rd_sel;

  modport master (output address, output wr_data, output wr_enable,
                  input  rd_data, input  rd_sel);
  modport slave  (input  address, input  wr_data, input  wr_enable,
                  output rd_data, output rd_sel);
endinterface

// File: rtl/timer_prescaler.sv
// Clock divider: emits a single-cycle tick every (prescale + 1) enabled clocks.
module timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] prescale,
  output logic       tick
);

  logic [7:0] ps;

  assign tick = en && (ps == prescale);

  // Held at zero while disabled so the first period after enabling is full length.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps <= 8'd0;
    end else if (!en || clr || tick) begin
      ps <= 8'd0;
    end else begin
      ps <= ps + 8'd1;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 16-bit interval timer with prescaler, auto-reload and level IRQ.
module bus_timer
  import timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hD000,
  parameter logic [15:0] RELOAD_RST = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  bus_timer_if.slave  bus,
  output logic        irq
);

  logic [15:0] count;
  logic [15:0] reload;
  logic [7:0]  shadow_hi;
  logic [7:0]  prescale;
  logic        en;
  logic        auto_rld;
  logic        irqen;
  logic        exp_flag;
  logic        tick;

  logic        hit_p0;
  logic        wr_hit_p0;
  logic        rd_hit_p0;
  logic [2:0]  off_p0;
  logic        load_p0;
  logic        ctrl_wr_p0;
  logic        expire_p0;
  logic        en_nxt;
  logic        irqen_nxt;
  logic        exp_nxt;
  logic [7:0]  rd_mux_p0;

  timer_prescaler u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clr      (load_p0),
    .prescale (prescale),
    .tick     (tick)
  );

  // Stage p0: address decode and next-state selection for control bits.
  always_comb begin
    hit_p0     = win_hit(bus.address, BASE_ADDR);
    off_p0     = bus.address[2:0];
    wr_hit_p0  = hit_p0 && bus.wr_enable;
    rd_hit_p0  = hit_p0 && !bus.wr_enable;
    ctrl_wr_p0 = wr_hit_p0 && (off_p0 == OFF_CTRL);
    load_p0    = ctrl_wr_p0 && bus.wr_data[CTRL_LOAD];
    // A LOAD in the same cycle overrides whatever the tick would have done.
    expire_p0  = tick && (count == 16'd0) && !load_p0;

    en_nxt    = en;
    irqen_nxt = irqen;
    if (ctrl_wr_p0) begin
      en_nxt    = bus.wr_data[CTRL_EN];
      irqen_nxt = bus.wr_data[CTRL_IRQEN];
    end else if (expire_p0 && !auto_rld) begin
      en_nxt = 1'b0;
    end

    exp_nxt = exp_flag;
    if (expire_p0) begin
      exp_nxt = 1'b1;
    end else if (wr_hit_p0 && (off_p0 == OFF_STATUS) && bus.wr_data[STATUS_EXP]) begin
      exp_nxt = 1'b0;
    end

    rd_mux_p0 = 8'h00;
    case (off_p0)
      OFF_CNT_LO:   rd_mux_p0 = count[7:0];
      OFF_CNT_HI:   rd_mux_p0 = shadow_hi;
      OFF_RLD_LO:   rd_mux_p0 = reload[7:0];
      OFF_RLD_HI:   rd_mux_p0 = reload[15:8];
      OFF_CTRL:     rd_mux_p0 = {5'b0, irqen, auto_rld, en};
      OFF_STATUS:   rd_mux_p0 = {7'b0, exp_flag};
      OFF_PRESCALE: rd_mux_p0 = prescale;
      OFF_RSVD:     rd_mux_p0 = 8'h00;
      default:      rd_mux_p0 = 8'h00;
    endcase
  end

  // Stage p1: register file, countdown and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= 16'd0;
      shadow_hi   <= 8'd0;
      reload      <= RELOAD_RST;
      prescale    <= 8'd0;
      en          <= 1'b0;
      auto_rld    <= 1'b0;
      irqen       <= 1'b0;
      exp_flag    <= 1'b0;
      irq         <= 1'b0;
      bus.rd_data <= 8'd0;
      bus.rd_sel  <= 1'b0;
    end else begin
      en       <= en_nxt;
      irqen    <= irqen_nxt;
      exp_flag <= exp_nxt;
      irq      <= exp_nxt && irqen_nxt;

      if (ctrl_wr_p0) begin
        auto_rld <= bus.wr_data[CTRL_AUTO];
      end
      if (wr_hit_p0 && (off_p0 == OFF_RLD_LO)) begin
        reload[7:0] <= bus.wr_data;
      end
      if (wr_hit_p0 && (off_p0 == OFF_RLD_HI)) begin
        reload[15:8] <= bus.wr_data;
      end
      if (wr_hit_p0 && (off_p0 == OFF_PRESCALE)) begin
        prescale <= bus.wr_data;
      end

      if (load_p0) begin
        count <= reload;
      end else if (tick) begin
        if (count != 16'd0) begin
          count <= count - 16'd1;
        end else if (auto_rld) begin
          count <= reload;
        end
      end

      // Reading the low byte freezes the high byte so a two-byte read is coherent.
      if (rd_hit_p0 && (off_p0 == OFF_CNT_LO)) begin
        shadow_hi <= count[15:8];
      end

      bus.rd_sel  <= rd_hit_p0;
      bus.rd_data <= rd_hit_p0 ? rd_mux_p0 : 8'h00;
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: register access, one-shot, auto-reload, W1C collision, latching, reset.
module tb_bus_timer;

  logic clk = 1'b0;
  logic reset;
  logic irq;
  int   errors = 0;
  int   checks = 0;

  bus_timer_if bif ();

  bus_timer #(.BASE_ADDR(16'hD000), .RELOAD_RST(16'hFFFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // One bus cycle: drive on the falling edge, observe 1 time unit after the rising edge.
  task automatic cyc(input logic [15:0] addr, input logic wr, input logic [7:0] data);
    @(negedge clk);
    bif.address   = addr;
    bif.wr_enable = wr;
    bif.wr_data   = data;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data);
    cyc(addr, 1'b1, data);
  endtask

  task automatic rd(input logic [15:0] addr);
    cyc(addr, 1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(16'h0000, 1'b0, 8'h00);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%02h want 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] exp);
    chk({tag, "_sel"}, {7'b0, bif.rd_sel}, 8'h01);
    chk(tag, bif.rd_data, exp);
  endtask

  initial begin
    bif.address   = 16'h0000;
    bif.wr_enable = 1'b0;
    bif.wr_data   = 8'h00;
    reset         = 1'b1;
    idle(3);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_sel", {7'b0, bif.rd_sel}, 8'h00);
    chk("rst_rd", bif.rd_data, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // Reset defaults and plain register access.
    rd(16'hD003);  chk_rd("def_rld_hi", 8'hFF);
    rd(16'hD002);  chk_rd("def_rld_lo", 8'hFF);
    rd(16'hD004);  chk_rd("def_ctrl", 8'h00);
    chk("def_irq", {7'b0, irq}, 8'h00);
    rd(16'h8000);
    chk("miss_sel", {7'b0, bif.rd_sel}, 8'h00);
    chk("miss_rd", bif.rd_data, 8'h00);
    wr(16'hD006, 8'h5A);
    chk("wr_sel", {7'b0, bif.rd_sel}, 8'h00);
    rd(16'hD006);  chk_rd("ps_rw", 8'h5A);
    wr(16'hD000, 8'h55);
    wr(16'hD007, 8'hAA);
    rd(16'hD000);  chk_rd("cnt_ro", 8'h00);
    rd(16'hD007);  chk_rd("rsvd", 8'h00);

    // One-shot: reload 3, prescale 0; expiry lands on the 4th edge after the CTRL write.
    wr(16'hD002, 8'h03);
    wr(16'hD003, 8'h00);
    wr(16'hD006, 8'h00);
    wr(16'hD004, 8'h0D);
    idle(3);
    chk("os_irq_pre", {7'b0, irq}, 8'h00);
    rd(16'hD005);  chk_rd("os_exp_e4", 8'h00);
    rd(16'hD005);  chk_rd("os_exp_e5", 8'h01);
    chk("os_irq", {7'b0, irq}, 8'h01);
    rd(16'hD004);  chk_rd("os_ctrl", 8'h04);
    rd(16'hD000);  chk_rd("os_cnt_lo", 8'h00);
    rd(16'hD001);  chk_rd("os_cnt_hi", 8'h00);
    wr(16'hD005, 8'h01);
    idle(1);
    chk("os_irq_clr", {7'b0, irq}, 8'h00);
    wr(16'hD004, 8'h00);

    // Auto-reload: reload 2, prescale 1 -> period 6 clocks, IRQ disabled.
    wr(16'hD002, 8'h02);
    wr(16'hD006, 8'h01);
    wr(16'hD004, 8'h0B);
    idle(5);
    rd(16'hD005);  chk_rd("ar_exp_w6", 8'h00);
    rd(16'hD005);  chk_rd("ar_exp_w7", 8'h01);
    chk("ar_irq1", {7'b0, irq}, 8'h00);
    wr(16'hD005, 8'h01);
    rd(16'hD005);  chk_rd("ar_exp_clr", 8'h00);
    idle(2);
    rd(16'hD005);  chk_rd("ar_exp_w12", 8'h00);
    rd(16'hD005);  chk_rd("ar_exp_w13", 8'h01);
    chk("ar_irq2", {7'b0, irq}, 8'h00);
    wr(16'hD004, 8'h00);
    wr(16'hD005, 8'h01);

    // W1C on the same edge as an expiry: set wins, irq stays high.
    wr(16'hD006, 8'h00);
    wr(16'hD004, 8'h0F);
    idle(5);
    chk("col_irq_pre", {7'b0, irq}, 8'h01);
    wr(16'hD005, 8'h01);
    chk("col_irq", {7'b0, irq}, 8'h01);
    rd(16'hD005);  chk_rd("col_exp", 8'h01);
    chk("col_irq2", {7'b0, irq}, 8'h01);

    // Reset mid-count with irq high.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_irq", {7'b0, irq}, 8'h00);
    chk("mr_sel", {7'b0, bif.rd_sel}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    rd(16'hD002);  chk_rd("mr_rld_lo", 8'hFF);
    rd(16'hD003);  chk_rd("mr_rld_hi", 8'hFF);
    rd(16'hD004);  chk_rd("mr_ctrl", 8'h00);
    rd(16'hD000);  chk_rd("mr_cnt_lo", 8'h00);
    rd(16'hD001);  chk_rd("mr_cnt_hi", 8'h00);

    // Latched read: count 0x0100 counting down every clock.
    wr(16'hD002, 8'h00);
    wr(16'hD003, 8'h01);
    wr(16'hD004, 8'h09);
    rd(16'hD000);  chk_rd("lat_lo", 8'h00);
    idle(1);
    rd(16'hD001);  chk_rd("lat_hi", 8'h01);
    rd(16'hD000);  chk_rd("lat_lo2", 8'hFD);
    rd(16'hD001);  chk_rd("lat_hi2", 8'h00);
    wr(16'hD004, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
